song_timer: RTL
===============

Name: song_timer

Overview:
- Beat-timing stage that produces the `fin_check` input consumed by the game-mode state machine.
- Watches the registered `mode` output from that FSM.
- Advances a beat/note address at a difficulty-dependent tempo while in RUN, freezes in PAUSE, and raises `fin_check` once the last beat of the song has elapsed.
- Drives the note-address and beat-strobe signals used by the note-fetch and display logic.

Parameters:
- DIV_EASY, 24'd12_000_000, clock cycles per beat for difficulty 0
- DIV_MED, 24'd8_000_000, clock cycles per beat for difficulty 1
- DIV_HARD, 24'd5_000_000, clock cycles per beat for difficulty 2 and 3
- SONG_LEN, 64, number of beats in the song (>=2)
- ADDR_W, 6, width of note_addr; must satisfy 2**ADDR_W >= SONG_LEN

Ports:
- clk  input  1  system clock; single clock domain
- n_rst  input  1  synchronous, active-low reset
- mode  input  3  game mode: 1 IDLE, 2 EDIT, 3 DIFF, 4 RUN, 5 PAUSE, 6 FINISH; 0 and 7 are treated as IDLE
- diff  input  2  difficulty selection, sampled only while mode==DIFF
- note_addr  output  ADDR_W  index of the current beat
- beat_strobe  output  1  one-cycle pulse per elapsed beat
- fin_check  output  1  song-complete flag to the mode FSM
- diff_lat  output  2  latched difficulty in use
- playing  output  1  high while mode==RUN and the song is not done

Behaviour:
- Clock, reset and output timing
  - Only clk is used; reset is synchronous and active-low.
  - While n_rst==0 at a rising edge: prescaler=0, note_addr=0, beat_strobe=0, done=0 (drives fin_check=0), diff_lat=0, playing=0.
  - All outputs are registered.
- Internal state
  - `prescaler`: 24-bit counter.
  - `done`: flag; fin_check = done.
  - `div_sel`: DIV_EASY when diff_lat==0, DIV_MED when diff_lat==1, otherwise DIV_HARD.
- Per-mode action at each clock edge
  - IDLE / EDIT / DIFF / invalid (0, 7): prescaler=0, note_addr=0, done=0, beat_strobe=0.
  - DIFF only, additionally: diff_lat<=diff every cycle. The value held when mode leaves DIFF is frozen.
  - RUN with done==0, prescaler!=div_sel-1: prescaler++.
  - RUN with done==0, prescaler==div_sel-1:
    - prescaler=0 and beat_strobe=1 for the next cycle.
    - If note_addr==SONG_LEN-1: done=1 and note_addr holds (no wrap).
    - Otherwise note_addr++.
  - RUN with done==1: everything holds and beat_strobe=0.
  - PAUSE: prescaler, note_addr and done hold; beat_strobe=0. Resuming RUN continues from the held prescaler value, so no partial beat is lost or restarted.
  - FINISH: done=0 and beat_strobe=0; note_addr and prescaler hold for score/display readout.
- beat_strobe is 0 on every cycle it is not explicitly set.
- fin_check stays high from the cycle after the last beat until mode==FINISH is seen. This guarantees the FSM catches it even if a RUN->PAUSE button press lands on the same cycle. It drops one cycle after FINISH is entered.
- playing = (mode==RUN) && !done, registered (one-cycle lag).
- Timing from RUN entry with prescaler=0:
  - The first beat_strobe is visible div_sel cycles after the first RUN cycle (strobe registered on the div_sel-th RUN edge).
  - fin_check rises together with the SONG_LEN-th strobe.
- The diff input is ignored outside DIFF; changes during RUN have no effect on tempo.
- Quit path: a direct jump from RUN/PAUSE to FINISH (done==0) leaves fin_check at 0 and freezes note_addr.
- Reset asserted mid-song returns the block to its reset values on the same edge, regardless of mode.
- Once done is set in RUN, prescaler never advances, so no spurious strobes occur.

Test Plan (overrides: DIV_EASY=8, DIV_MED=6, DIV_HARD=4, SONG_LEN=4, ADDR_W=2):
- Reset: hold n_rst=0 for 2 cycles with mode=RUN -> all outputs 0. Release, mode=RUN, diff_lat=0 -> first beat_strobe 8 cycles later and note_addr=1.
- Difficulty latch and full song: mode=DIFF with diff=2, then RUN for 16 cycles -> strobes every 4 cycles, note_addr 1,2,3,3. fin_check rises with the 4th strobe and stays high; mode=FINISH -> fin_check=0 one cycle later, note_addr=3.
- Pause: diff_lat=1, RUN for 3 cycles, PAUSE for 10 cycles, then RUN -> no strobe during PAUSE; strobe arrives 3 RUN cycles after resume, note_addr=1.
- Quit: diff_lat=0, RUN until note_addr=2, then mode=FINISH -> fin_check stays 0, note_addr holds at 2. Then IDLE -> note_addr=0.
- diff ignored outside DIFF and invalid mode: diff=3 during RUN at diff_lat=0 -> period stays 8. mode=7 mid-song -> counters clear as in IDLE.
- Finish/pause collision: mode goes RUN->PAUSE on the same cycle the last strobe fires -> fin_check=1 held in PAUSE until mode==FINISH.

Source files
------------

// File: rtl/song_timer.sv
// Beat timer: advances note_addr at a difficulty-selected tempo in RUN, holds in PAUSE, flags song end.
// All outputs registered (1-cycle latency); no backpressure, the mode input alone gates progress.
module song_timer #(
    parameter logic [23:0] DIV_EASY = 24'd12_000_000,
    parameter logic [23:0] DIV_MED  = 24'd8_000_000,
    parameter logic [23:0] DIV_HARD = 24'd5_000_000,
    parameter int          SONG_LEN = 64,
    parameter int          ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [2:0]        mode,
    input  logic [1:0]        diff,
    output logic [ADDR_W-1:0] note_addr,
    output logic              beat_strobe,
    output logic              fin_check,
    output logic [1:0]        diff_lat,
    output logic              playing
);

    localparam logic [2:0] MODE_DIFF   = 3'd3;
    localparam logic [2:0] MODE_RUN    = 3'd4;
    localparam logic [2:0] MODE_PAUSE  = 3'd5;
    localparam logic [2:0] MODE_FINISH = 3'd6;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    logic [23:0] prescaler;
    logic [23:0] div_sel;
    logic        done;
    logic        beat_end;

    always_comb begin
        div_sel = DIV_HARD;
        if (diff_lat == 2'd0) begin
            div_sel = DIV_EASY;
        end else if (diff_lat == 2'd1) begin
            div_sel = DIV_MED;
        end
    end

    assign beat_end  = (prescaler == div_sel - 24'd1);
    assign fin_check = done;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            prescaler   <= 24'd0;
            note_addr   <= '0;
            beat_strobe <= 1'b0;
            done        <= 1'b0;
            diff_lat    <= 2'd0;
            playing     <= 1'b0;
        end else begin
            beat_strobe <= 1'b0;
            playing     <= (mode == MODE_RUN) && !done;
            case (mode)
                MODE_RUN: begin
                    // Once done, everything freezes so no stray strobes appear
                    if (!done) begin
                        if (beat_end) begin
                            prescaler   <= 24'd0;
                            beat_strobe <= 1'b1;
                            if (note_addr == LAST_ADDR) begin
                                done <= 1'b1;
                            end else begin
                                note_addr <= note_addr + ADDR_W'(1);
                            end
                        end else begin
                            prescaler <= prescaler + 24'd1;
                        end
                    end
                end
                MODE_PAUSE: begin
                end
                // done stays up until FINISH so the mode FSM cannot miss it
                MODE_FINISH: begin
                    done <= 1'b0;
                end
                MODE_DIFF: begin
                    prescaler <= 24'd0;
                    note_addr <= '0;
                    done      <= 1'b0;
                    diff_lat  <= diff;
                end
                default: begin
                    prescaler <= 24'd0;
                    note_addr <= '0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
